// File: rtl/uart_pkg.sv
// Shared UART receive constants and state encoding.
package uart_pkg;

    localparam int unsigned BAUD               = 115200;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned BYTES_PER_WORD     = 2;
    localparam int unsigned WORD_BITS          = DATA_BITS * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw line through two stages.
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // Synchronizer flops, held at the idle level during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/receptor.sv
// Oversampling UART receiver: two 8N1 frames assembled into one 16-bit word.
module receptor
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE   = DEFAULT_OVERSAMPLE,
    parameter int unsigned TIMEOUT_BITS = 4
) (
    input  logic                 clk_1843200hz,
    input  logic                 reset,
    input  logic                 in,
    output logic [WORD_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int unsigned HALF   = OVERSAMPLE / 2;
    localparam int unsigned TO_CYC = OVERSAMPLE * TIMEOUT_BITS;
    localparam int unsigned CW     = $clog2(TO_CYC) + 1;

    logic rx_s;

    rx_state_t              state_q,  state_d;
    logic [CW-1:0]          cnt_q,    cnt_d;
    logic [3:0]             bit_q,    bit_d;
    logic                   idx_q,    idx_d;
    logic [DATA_BITS-1:0]   shift_q,  shift_d;
    logic [DATA_BITS-1:0]   byte0_q,  byte0_d;
    logic [WORD_BITS-1:0]   data_q,   data_d;
    logic                   valid_q,  valid_d;
    logic                   ferr_q,   ferr_d;
    logic                   terr_q,   terr_d;
    logic                   busy_q,   busy_d;

    rx_sync u_rx_sync (
        .clk   (clk_1843200hz),
        .reset (reset),
        .d     (in),
        .q     (rx_s)
    );

    // Frame sequencing, mid-bit sampling and word assembly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte0_d = byte0_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        terr_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    idx_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_d = ST_IDLE;
                        idx_d   = 1'b0;
                        ferr_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DATA: begin
                if (cnt_q == CW'(OVERSAMPLE - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_STOP: begin
                if (cnt_q == CW'(OVERSAMPLE - 1)) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_IDLE;
                        idx_d   = 1'b0;
                        ferr_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (!idx_q) begin
                        state_d = ST_GAP;
                        byte0_d = shift_q;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = 1'b0;
                        data_d  = {byte0_q, shift_q};
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_GAP: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    idx_d   = 1'b1;
                end else if (cnt_q == CW'(TO_CYC - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = 1'b0;
                    terr_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any partial word silently.
    always_ff @(posedge clk_1843200hz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            idx_q   <= 1'b0;
            shift_q <= '0;
            byte0_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte0_q <= byte0_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            terr_q  <= terr_d;
            busy_q  <= busy_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_err   = ferr_q;
    assign timeout_err = terr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_receptor.sv
// Directed bench for receptor: vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_receptor;

    localparam int CLK_NS = 10;
    localparam int BIT_NS = 16 * CLK_NS;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_line;
    logic [15:0] data;
    logic        valid;
    logic        frame_err;
    logic        timeout_err;
    logic        busy;

    receptor #(.OVERSAMPLE(16), .TIMEOUT_BITS(4)) dut (
        .clk_1843200hz (clk),
        .reset         (reset),
        .in            (rx_line),
        .data          (data),
        .valid         (valid),
        .frame_err     (frame_err),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    always #(CLK_NS / 2) clk = ~clk;

    // Pulse monitor: cumulative counts, read as deltas by the stimulus process.
    int          n_valid = 0, n_ferr = 0, n_terr = 0, n_excl = 0, n_busy_bad = 0;
    logic [15:0] last_data = 16'h0;
    logic        busy_prev = 1'b0;

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            last_data = data;
            if (busy || !busy_prev) n_busy_bad++;
        end
        if (frame_err)   n_ferr++;
        if (timeout_err) n_terr++;
        if (32'(valid) + 32'(frame_err) + 32'(timeout_err) > 1) n_excl++;
        busy_prev = busy;
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One 8N1 frame; a low stop bit is held for 3/4 of a bit, then released.
    task automatic send_byte(input logic [7:0] b, input int bit_ns, input bit stop_low);
        rx_line = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            #(bit_ns);
        end
        if (stop_low) begin
            rx_line = 1'b0;
            #(bit_ns * 3 / 4);
            rx_line = 1'b1;
            #(bit_ns - bit_ns * 3 / 4);
        end else begin
            rx_line = 1'b1;
            #(bit_ns);
        end
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          gap_bits;
        bit          stop_low;
        int          exp_valid;
        bit          exp_ferr;
        bit          exp_terr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[5];
    int v0, f0, t0;

    initial begin
        // A 5-bit gap times out byte 0; byte 1 then restarts as a new byte 0 and times out too.
        vecs[0] = '{8'hA5, 8'h3C, 0, 1'b0, 1, 1'b0, 1'b0, 16'hA53C};
        vecs[1] = '{8'h01, 8'h80, 3, 1'b0, 1, 1'b0, 1'b0, 16'h0180};
        vecs[2] = '{8'h01, 8'h80, 5, 1'b0, 0, 1'b0, 1'b1, 16'h0180};
        vecs[3] = '{8'h11, 8'h22, 0, 1'b1, 0, 1'b1, 1'b0, 16'h0180};
        vecs[4] = '{8'hFF, 8'hFF, 0, 1'b0, 1, 1'b0, 1'b0, 16'hFFFF};

        reset   = 1'b1;
        rx_line = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset data",  32'(data), 32'h0);
        check("reset valid", 32'(valid), 0);
        check("reset ferr",  32'(frame_err), 0);
        check("reset terr",  32'(timeout_err), 0);
        check("reset busy",  32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        // Idle line for 100 bit periods.
        #(100 * BIT_NS);
        check("idle pulses", 32'(n_valid + n_ferr + n_terr), 0);
        check("idle busy",   32'(busy), 0);
        check("idle data",   32'(data), 32'h0);

        for (int i = 0; i < 5; i++) begin
            v0 = n_valid; f0 = n_ferr; t0 = n_terr;
            send_byte(vecs[i].b0, BIT_NS, 1'b0);
            #(vecs[i].gap_bits * BIT_NS);
            send_byte(vecs[i].b1, BIT_NS, vecs[i].stop_low);
            #(10 * BIT_NS);
            check($sformatf("row%0d valid", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
            check($sformatf("row%0d ferr", i),  32'(n_ferr != f0), 32'(vecs[i].exp_ferr));
            check($sformatf("row%0d terr", i),  32'(n_terr != t0), 32'(vecs[i].exp_terr));
            check($sformatf("row%0d data", i),  32'(data), 32'(vecs[i].exp_data));
            check($sformatf("row%0d busy", i),  32'(busy), 0);
        end

        // Short low glitch on an idle line, then a clean word.
        v0 = n_valid; f0 = n_ferr; t0 = n_terr;
        rx_line = 1'b0;
        #(4 * CLK_NS);
        rx_line = 1'b1;
        #(2 * BIT_NS);
        check("glitch ferr",  32'(n_ferr - f0), 1);
        check("glitch valid", 32'(n_valid - v0), 0);
        check("glitch busy",  32'(busy), 0);
        send_byte(8'h12, BIT_NS, 1'b0);
        send_byte(8'h34, BIT_NS, 1'b0);
        #(2 * BIT_NS);
        check("after glitch data",  32'(data), 32'h1234);
        check("after glitch valid", 32'(n_valid - v0), 1);

        // Reset during byte 1 data bits; the transmission is abandoned.
        send_byte(8'hDE, BIT_NS, 1'b0);
        rx_line = 1'b0; #(BIT_NS);
        rx_line = 1'b1; #(BIT_NS);
        rx_line = 1'b0; #(BIT_NS);
        check("midframe busy", 32'(busy), 1);
        @(negedge clk);
        reset   = 1'b1;
        rx_line = 1'b1;
        @(posedge clk);
        #1;
        check("midreset data",  32'(data), 32'h0);
        check("midreset valid", 32'(valid), 0);
        check("midreset ferr",  32'(frame_err), 0);
        check("midreset terr",  32'(timeout_err), 0);
        check("midreset busy",  32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        v0 = n_valid; f0 = n_ferr; t0 = n_terr;
        #(15 * BIT_NS);
        check("post reset quiet", 32'((n_valid - v0) + (n_ferr - f0) + (n_terr - t0)), 0);
        send_byte(8'hBE, BIT_NS, 1'b0);
        send_byte(8'hEF, BIT_NS, 1'b0);
        #(2 * BIT_NS);
        check("after reset data",  32'(data), 32'hBEEF);
        check("after reset valid", 32'(n_valid - v0), 1);

        // Transmitter bit period skewed about -2% and +2%.
        for (int s = 0; s < 2; s++) begin
            v0 = n_valid;
            f0 = n_ferr;
            send_byte(8'h5A, (s == 0) ? 157 : 163, 1'b0);
            send_byte(8'hC3, (s == 0) ? 157 : 163, 1'b0);
            #(2 * BIT_NS);
            check($sformatf("skew%0d data", s),  32'(data), 32'h5AC3);
            check($sformatf("skew%0d valid", s), 32'(n_valid - v0), 1);
            check($sformatf("skew%0d ferr", s),  32'(n_ferr - f0), 0);
            check($sformatf("skew%0d last", s),  32'(last_data), 32'h5AC3);
        end

        check("pulse exclusivity", 32'(n_excl), 0);
        check("busy falls with valid", 32'(n_busy_bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
